mdp3_book_pipeline: RTL and testbench
=====================================

Name: mdp3_book_pipeline

Overview:
- Single-security market-data front end: takes a framed 64-bit beat stream, reassembles one fixed-layout 37-byte MDP3 incremental-refresh message per packet, and decodes its fields.
- Maintains a DEPTH-level bid/ask price-level book for one security ID.
- Sits between the Ethernet/UDP payload extractor and the strategy logic.

Parameters:
- SECURITY_ID, 123, only messages carrying this security ID update the book.
- DEPTH, 10, number of price levels per side.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- EN  in  1  beat enable; when low, the input beat is ignored and all state holds.
- data_in  in  64  payload beat; byte 0 of each beat is data_in[63:56].
- start_packet  in  1  high while idle/preamble; a message starts on the first EN beat with start_packet low.
- end_packet  in  1  marks the last beat of a message.
- msg_valid  out  1  one-cycle pulse when a complete message is decoded.
- security_id  out  32  decoded field.
- action  out  2  decoded field.
- entry_type  out  2  decoded field.
- price  out  64  decoded field.
- quantity  out  16  decoded field.
- num_orders  out  8  decoded field.
- price_level  out  8  decoded field.
- bids  out  88*DEPTH  level i (0 = best) at [88*i+87 : 88*i].
- asks  out  88*DEPTH  same packing as bids.
- book_updated  out  1  one-cycle pulse when the book changes.

Behaviour:
- Reset: all outputs, book entries, field registers and beat counter go to 0.
- Framing:
  - Beat counter clears while start_packet=1.
  - Each EN beat with start_packet=0 stores the beat at index 0..4 (byte offset 8*index).
  - Beats beyond index 4 are ignored.
  - Packet ends on the EN beat with end_packet=1.
  - If end_packet arrives before 5 beats have been stored, the message is discarded: no msg_valid and no book change.
  - start_packet=1 mid-message aborts the message.
- Message layout (37 bytes, multi-byte fields little-endian):
  - bytes 0-11: header, ignored.
  - byte 12: action (0 = New, 1 = Change, 2 = Delete; low 2 bits).
  - byte 13: entry_type (0 = bid, 1 = ask).
  - bytes 14-17: security_id.
  - bytes 18-21: rpt_seq, ignored.
  - bytes 22-29: price.
  - bytes 30-31: quantity.
  - byte 32: price_level (1-based).
  - byte 33: num_orders.
  - bytes 34-36: pad.
- Decode timing: field outputs load, and msg_valid pulses, on the edge after the edge that samples the end beat. Field outputs hold until the next message.
- Book entry format: {price[63:0], quantity[15:0], num_orders[7:0]}.
- Book update: on the edge after msg_valid is high, and only if security_id == SECURITY_ID, entry_type is 0 or 1, and 1 ≤ price_level ≤ DEPTH. Let L = price_level-1 on the selected side.
  - New: levels L..DEPTH-2 shift to L+1..DEPTH-1; the old last level is dropped; the new entry is written at L.
  - Change: level L is overwritten; other levels are unchanged.
  - Delete: levels L+1..DEPTH-1 shift up by one; the last level becomes 0.
  - action 3, a mismatched security ID, an invalid side, or an out-of-range level: no change and no book_updated.
- book_updated pulses high for one cycle after the book registers change. The other side is never touched.
- Back-to-back messages are supported with zero idle beats; one update completes per message.
- EN low during the update pipeline does not stall the decode/update stages; EN gates input beats only.

Test Plan:
- Reset then idle: all outputs 0 and no pulses.
- Six idle beats with start_packet=1, then bytes C0C21C023D0100006803800100007B0000000C0000000900000000000000AE0001C9000000 over 5 beats, with end_packet on the 5th beat (40 valid bits, left-aligned) → msg_valid pulses with action 0, entry_type 0, security_id 123, price 9, quantity 174, price_level 1, num_orders 201. Next cycle book_updated pulses and bids level 0 = {64'd9, 16'd174, 8'd201}.
- Follow with the message whose bytes 12-13 are 01 00, price 5, quantity 5, level 2 → bid level 1 = {5, 5, 201}; bid level 0 is unchanged.
- Message with bytes 12-13 = 00 01, price 3, quantity 1024, level 3 → ask level 2 = {3, 1024, 201}; bids are unchanged.
- Insert bids at level 1 with prices 9 then 8 (New) → level 0 = 8, level 1 = 9. Delete level 1 → level 0 = 9 and level DEPTH-1 = 0.
- Security_id 122, price_level 11, or end_packet on beat 3 → no book_updated and the book is unchanged.

Source files
------------

// File: rtl/mdp3_book_pipeline.sv
// MDP3 incremental-refresh front end: reassembles one 37-byte message from 64-bit beats,
// decodes its fields and applies New/Change/Delete to a DEPTH-level bid/ask book.
module mdp3_book_pipeline #(
    parameter int SECURITY_ID = 123,
    parameter int DEPTH       = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  EN,
    input  logic [63:0]           data_in,
    input  logic                  start_packet,
    input  logic                  end_packet,
    output logic                  msg_valid,
    output logic [31:0]           security_id,
    output logic [1:0]            action,
    output logic [1:0]            entry_type,
    output logic [63:0]           price,
    output logic [15:0]           quantity,
    output logic [7:0]            num_orders,
    output logic [7:0]            price_level,
    output logic [88*DEPTH-1:0]   bids,
    output logic [88*DEPTH-1:0]   asks,
    output logic                  book_updated
);

    localparam logic [31:0] SEC_ID  = SECURITY_ID[31:0];
    localparam logic [7:0]  DEPTH_B = DEPTH[7:0];

    logic [2:0]  beat_cnt_q;
    logic        end_seen_q;
    logic [1:0]  act_s_q, et_s_q;
    logic [31:0] sec_s_q;
    logic [63:0] price_s_q;
    logic [15:0] qty_s_q;
    logic [7:0]  lvl_s_q, nord_s_q;

    logic        msg_valid_q, book_updated_q;
    logic [1:0]  action_q, entry_type_q;
    logic [31:0] security_id_q;
    logic [63:0] price_q;
    logic [15:0] quantity_q;
    logic [7:0]  price_level_q, num_orders_q;

    logic [87:0] bid_q [DEPTH];
    logic [87:0] ask_q [DEPTH];
    logic [87:0] bid_d [DEPTH];
    logic [87:0] ask_d [DEPTH];
    logic [87:0] side_cur [DEPTH];
    logic [87:0] side_d   [DEPTH];
    logic [87:0] new_entry;
    logic        hit;
    int          lvl;

    // Field bytes are captured straight out of their beat, little-endian fields byte-swapped on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            end_seen_q <= 1'b0;
            act_s_q    <= '0;
            et_s_q     <= '0;
            sec_s_q    <= '0;
            price_s_q  <= '0;
            qty_s_q    <= '0;
            lvl_s_q    <= '0;
            nord_s_q   <= '0;
        end else begin
            end_seen_q <= 1'b0;
            if (EN) begin
                if (start_packet) begin
                    beat_cnt_q <= '0;
                end else begin
                    case (beat_cnt_q)
                        3'd1: begin
                            act_s_q       <= data_in[25:24];
                            et_s_q        <= data_in[17:16];
                            sec_s_q[7:0]  <= data_in[15:8];
                            sec_s_q[15:8] <= data_in[7:0];
                        end
                        3'd2: begin
                            sec_s_q[23:16]  <= data_in[63:56];
                            sec_s_q[31:24]  <= data_in[55:48];
                            price_s_q[7:0]  <= data_in[15:8];
                            price_s_q[15:8] <= data_in[7:0];
                        end
                        3'd3: begin
                            price_s_q[23:16] <= data_in[63:56];
                            price_s_q[31:24] <= data_in[55:48];
                            price_s_q[39:32] <= data_in[47:40];
                            price_s_q[47:40] <= data_in[39:32];
                            price_s_q[55:48] <= data_in[31:24];
                            price_s_q[63:56] <= data_in[23:16];
                            qty_s_q[7:0]     <= data_in[15:8];
                            qty_s_q[15:8]    <= data_in[7:0];
                        end
                        3'd4: begin
                            lvl_s_q  <= data_in[63:56];
                            nord_s_q <= data_in[55:48];
                        end
                        default: ;
                    endcase
                    if (end_packet) begin
                        beat_cnt_q <= '0;
                        end_seen_q <= (beat_cnt_q >= 3'd4);
                    end else if (beat_cnt_q < 3'd5) begin
                        beat_cnt_q <= beat_cnt_q + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_valid_q   <= 1'b0;
            action_q      <= '0;
            entry_type_q  <= '0;
            security_id_q <= '0;
            price_q       <= '0;
            quantity_q    <= '0;
            price_level_q <= '0;
            num_orders_q  <= '0;
        end else begin
            msg_valid_q <= end_seen_q;
            if (end_seen_q) begin
                action_q      <= act_s_q;
                entry_type_q  <= et_s_q;
                security_id_q <= sec_s_q;
                price_q       <= price_s_q;
                quantity_q    <= qty_s_q;
                price_level_q <= lvl_s_q;
                num_orders_q  <= nord_s_q;
            end
        end
    end

    always_comb begin
        bid_d     = bid_q;
        ask_d     = ask_q;
        side_cur  = bid_q;
        new_entry = {price_q, quantity_q, num_orders_q};
        hit       = msg_valid_q && (security_id_q == SEC_ID) && !entry_type_q[1] &&
                    (price_level_q != 8'd0) && (price_level_q <= DEPTH_B) && (action_q != 2'd3);
        lvl       = int'(price_level_q) - 1;
        if (entry_type_q[0]) begin
            side_cur = ask_q;
        end
        side_d = side_cur;
        case (action_q)
            2'd0: begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i > lvl) side_d[i] = side_cur[i-1];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == lvl) side_d[i] = new_entry;
                end
            end
            2'd1: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == lvl) side_d[i] = new_entry;
                end
            end
            2'd2: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (i >= lvl) side_d[i] = side_cur[i+1];
                end
                side_d[DEPTH-1] = '0;
            end
            default: ;
        endcase
        if (hit) begin
            if (entry_type_q[0]) ask_d = side_d;
            else                 bid_d = side_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            book_updated_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bid_q[i] <= '0;
                ask_q[i] <= '0;
            end
        end else begin
            book_updated_q <= hit;
            bid_q          <= bid_d;
            ask_q          <= ask_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign bids[88*g +: 88] = bid_q[g];
        assign asks[88*g +: 88] = ask_q[g];
    end

    assign msg_valid    = msg_valid_q;
    assign security_id  = security_id_q;
    assign action       = action_q;
    assign entry_type   = entry_type_q;
    assign price        = price_q;
    assign quantity     = quantity_q;
    assign num_orders   = num_orders_q;
    assign price_level  = price_level_q;
    assign book_updated = book_updated_q;

endmodule

// File: tb/tb_mdp3_book_pipeline.sv
// Directed bench for mdp3_book_pipeline: hand-built messages, expected book contents worked out by hand.
module tb_mdp3_book_pipeline;

    localparam int DEPTH = 10;
    localparam logic [319:0] BASE =
        320'hC0C21C023D010000_6803800100007B00_00000C0000000900_000000000000AE00_01C9000000000000;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               EN = 1'b0;
    logic [63:0]        data_in = '0;
    logic               start_packet = 1'b1;
    logic               end_packet = 1'b0;
    logic               msg_valid, book_updated;
    logic [31:0]        security_id;
    logic [1:0]         action, entry_type;
    logic [63:0]        price;
    logic [15:0]        quantity;
    logic [7:0]         num_orders, price_level;
    logic [88*DEPTH-1:0] bids, asks;

    mdp3_book_pipeline #(.SECURITY_ID(123), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .EN(EN), .data_in(data_in),
        .start_packet(start_packet), .end_packet(end_packet),
        .msg_valid(msg_valid), .security_id(security_id), .action(action),
        .entry_type(entry_type), .price(price), .quantity(quantity),
        .num_orders(num_orders), .price_level(price_level),
        .bids(bids), .asks(asks), .book_updated(book_updated)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;
    int n_mv = 0, n_bu = 0;

    always @(negedge clk) begin
        if (msg_valid)    n_mv++;
        if (book_updated) n_bu++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] mk(input logic [1:0] act, input logic [7:0] et,
                                        input logic [31:0] sec, input logic [63:0] pr,
                                        input logic [15:0] qty, input logic [7:0] lvl);
        logic [319:0] m;
        m = BASE;
        m[319-8*12 -: 8] = {6'd0, act};
        m[319-8*13 -: 8] = et;
        for (int k = 0; k < 4; k++) m[319-8*(14+k) -: 8] = sec[8*k +: 8];
        for (int k = 0; k < 8; k++) m[319-8*(22+k) -: 8] = pr[8*k +: 8];
        for (int k = 0; k < 2; k++) m[319-8*(30+k) -: 8] = qty[8*k +: 8];
        m[319-8*32 -: 8] = lvl;
        return m;
    endfunction

    function automatic logic [87:0] ent(input logic [63:0] p, input logic [15:0] q, input logic [7:0] n);
        return {p, q, n};
    endfunction

    function automatic logic [87:0] bid(input int i);
        return bids[88*i +: 88];
    endfunction

    function automatic logic [87:0] ask(input int i);
        return asks[88*i +: 88];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap inserts an EN-low beat (with garbage and end_packet high) before every real beat.
    task automatic send(input logic [319:0] m, input int nb, input bit b2b, input bit gap);
        for (int k = 0; k < nb; k++) begin
            if (gap) begin
                @(negedge clk);
                EN = 1'b0; start_packet = 1'b0; end_packet = 1'b1; data_in = '1;
            end
            @(negedge clk);
            EN = 1'b1; start_packet = 1'b0;
            data_in = m[319-64*k -: 64];
            end_packet = (k == nb - 1);
        end
        if (!b2b) begin
            @(negedge clk);
            EN = 1'b0; start_packet = 1'b1; end_packet = 1'b0; data_in = '0;
        end
    endtask

    task automatic neg(input string tag, input logic [319:0] m, input int nb, input int exp_mv);
        logic [88*DEPTH-1:0] sb, sa;
        int mv0, bu0;
        sb = bids; sa = asks; mv0 = n_mv; bu0 = n_bu;
        send(m, nb, 1'b0, 1'b0);
        repeat (4) tick();
        chk({tag, "_bu"}, n_bu - bu0, 0);
        chk({tag, "_mv"}, n_mv - mv0, exp_mv);
        chk({tag, "_book"}, (bids == sb) && (asks == sa), 1);
    endtask

    initial begin
        logic [88*DEPTH-1:0] snap;
        int mv0, bu0;

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_mv", msg_valid, 0);
        chk("rst_bu", book_updated, 0);
        chk("rst_sec", security_id, 0);
        chk("rst_price", price, 0);
        chk("rst_lvl", price_level, 0);
        chk("rst_book", (bids == '0) && (asks == '0), 1);

        mv0 = n_mv; bu0 = n_bu;
        @(negedge clk); EN = 1'b1; start_packet = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_mv", n_mv - mv0, 0);
        chk("idle_bu", n_bu - bu0, 0);

        send(BASE, 5, 1'b0, 1'b0);
        tick();
        chk("m1_mv", msg_valid, 1);
        chk("m1_act", action, 0);
        chk("m1_et", entry_type, 0);
        chk("m1_sec", security_id, 123);
        chk("m1_price", price, 9);
        chk("m1_qty", quantity, 174);
        chk("m1_lvl", price_level, 1);
        chk("m1_nord", num_orders, 201);
        chk("m1_bu_early", book_updated, 0);
        tick();
        chk("m1_bu", book_updated, 1);
        chk("m1_mv_off", msg_valid, 0);
        chk("m1_bid0", bid(0), ent(9, 174, 201));
        tick();
        chk("m1_bu_off", book_updated, 0);
        chk("m1_price_hold", price, 9);

        send(mk(2'd1, 8'd0, 123, 5, 5, 2), 5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("chg_bid1", bid(1), ent(5, 5, 201));
        chk("chg_bid0", bid(0), ent(9, 174, 201));

        snap = bids;
        send(mk(2'd0, 8'd1, 123, 3, 1024, 3), 5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("ask_lvl2", ask(2), ent(3, 1024, 201));
        chk("ask_bids_hold", bids == snap, 1);

        bu0 = n_bu;
        send(mk(2'd0, 8'd0, 123, 9, 1, 1), 5, 1'b1, 1'b0);
        send(mk(2'd0, 8'd0, 123, 8, 1, 1), 5, 1'b0, 1'b0);
        repeat (4) tick();
        chk("b2b_bu_cnt", n_bu - bu0, 2);
        chk("ins_bid0", bid(0), ent(8, 1, 201));
        chk("ins_bid1", bid(1), ent(9, 1, 201));
        chk("ins_bid2", bid(2), ent(9, 174, 201));
        chk("ins_bid3", bid(3), ent(5, 5, 201));

        send(mk(2'd2, 8'd0, 123, 0, 0, 1), 5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("del_bid0", bid(0), ent(9, 1, 201));
        chk("del_bid2", bid(2), ent(5, 5, 201));
        chk("del_bid3", bid(3), 0);
        chk("del_bid9", bid(DEPTH-1), 0);

        send(mk(2'd0, 8'd0, 123, 7, 7, 10), 5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("lvl10_bid9", bid(9), ent(7, 7, 201));
        chk("lvl10_bid2", bid(2), ent(5, 5, 201));

        neg("sec122", mk(2'd0, 8'd0, 122, 4, 4, 1), 5, 1);
        neg("lvl11", mk(2'd0, 8'd0, 123, 4, 4, 11), 5, 1);
        neg("lvl0", mk(2'd0, 8'd0, 123, 4, 4, 0), 5, 1);
        neg("act3", mk(2'd3, 8'd0, 123, 4, 4, 1), 5, 1);
        neg("side2", mk(2'd0, 8'd2, 123, 4, 4, 1), 5, 1);
        neg("short", mk(2'd0, 8'd0, 123, 4, 4, 1), 3, 0);

        send(mk(2'd1, 8'd1, 123, 6, 6, 1), 5, 1'b0, 1'b1);
        repeat (3) tick();
        chk("gap_ask0", ask(0), ent(6, 6, 201));
        chk("gap_ask2", ask(2), ent(3, 1024, 201));

        mv0 = n_mv;
        send(mk(2'd0, 8'd1, 123, 99, 99, 1), 2, 1'b1, 1'b0);
        @(negedge clk);
        EN = 1'b1; start_packet = 1'b1; end_packet = 1'b0;
        send(mk(2'd0, 8'd1, 123, 11, 2, 1), 5, 1'b0, 1'b0);
        repeat (4) tick();
        chk("abort_mv", n_mv - mv0, 1);
        chk("abort_ask0", ask(0), ent(11, 2, 201));
        chk("abort_ask1", ask(1), ent(6, 6, 201));
        chk("abort_ask3", ask(3), ent(3, 1024, 201));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
